uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter BAUD_DIV, default 104, clk cycles per serial bit (12 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  master clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 data_in  input  8  byte to transmit; sampled only on acceptance.
REQ-005 data_valid  input  1  upstream has a byte on data_in.
REQ-006 data_ready  output  1  framer can accept a byte this cycle.
REQ-007 tx  output  1  serial line, idle HIGH.
REQ-008 busy  output  1  HIGH while a frame is in progress.

Function
REQ-009 The block SHALL accept a byte only in a cycle where data_valid and data_ready are both HIGH; the byte is captured into an internal 8-bit holding register.
REQ-010 data_ready SHALL be HIGH only in state IDLE with rst HIGH; it SHALL be combinationally independent of data_valid.
REQ-011 The block SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 IDLE -> START on acceptance; START -> DATA after BAUD_DIV cycles; DATA -> STOP (or PARITY) after 8 bit periods; PARITY -> STOP after BAUD_DIV cycles; STOP -> IDLE after BAUD_DIV cycles.
REQ-013 tx SHALL be LOW in START, data bit n (LSB first, n = 0..7) in DATA, parity bit in PARITY, HIGH in STOP and IDLE; tx is registered.
REQ-014 tx SHALL go LOW in the first cycle after the acceptance edge (latency 1 cycle) and each bit SHALL last exactly BAUD_DIV cycles.
REQ-015 The baud counter SHALL count 0..BAUD_DIV-1, restart at 0 on every bit boundary and state change, with width clog2(BAUD_DIV).
REQ-016 The 3-bit bit counter SHALL wrap from 7 to 0 on the DATA exit transition, never mid-frame.
REQ-017 busy SHALL be HIGH in every state except IDLE.
REQ-018 Changes on data_in or data_valid during a frame SHALL NOT affect the frame in progress.
REQ-019 Back-to-back: if data_valid is HIGH on the first IDLE cycle after STOP, the next byte SHALL be accepted then, giving a frame period of 10*BAUD_DIV+1 cycles (11*BAUD_DIV+1 with parity).
REQ-020 data_valid LOW in IDLE SHALL hold tx HIGH indefinitely.

Reset
REQ-021 While rst is LOW at a clock edge: state IDLE, tx=1, busy=0, counters and holding register 0.
REQ-022 data_ready SHALL be 0 while rst is LOW and 1 in the first cycle after rst returns HIGH.
REQ-023 Reset asserted mid-frame SHALL abort the frame; tx SHALL be HIGH on the next cycle and no partial byte resumes.

Configuration
REQ-024 Macro UART_TX_FRAMER_PARITY_EN, when defined, SHALL insert an even-parity bit (XOR of the 8 data bits) in state PARITY between DATA and STOP.
REQ-025 Without UART_TX_FRAMER_PARITY_EN, state PARITY and its logic SHALL NOT exist and DATA goes directly to STOP.

Verification (BAUD_DIV=4)
REQ-026 Reset, then data_in=0x55 with data_valid pulsed 1 cycle -> tx LOW 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, HIGH stop 4 cycles; busy HIGH for 40 cycles.
REQ-027 data_valid held HIGH with 0xA3 then 0x0F -> two frames, second start bit begins 41 cycles after the first; data_ready HIGH for exactly 1 cycle between them.
REQ-028 rst LOW during data bit 3 of 0xFF -> tx=1, busy=0 next cycle; data_ready HIGH 1 cycle after rst released.
REQ-029 data_in toggled every cycle during frame of 0x81 -> serial bits remain 1,0,0,0,0,0,0,1.
REQ-030 With UART_TX_FRAMER_PARITY_EN, 0x07 -> parity bit 1 after bit 7, frame 44 cycles; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_framer.sv
// 8N1 UART transmit framer with valid/ready byte intake and registered tx.
// Define UART_TX_FRAMER_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_framer #(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_FRAMER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    hold_q, hold_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          accept;

  assign data_ready = (state_q == S_IDLE) & rst;
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign bit_end    = (baud_q == BAUD_LAST);
  assign accept     = data_valid & data_ready;

  // tx_d is computed for the state being entered so tx stays registered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (accept) begin
          hold_d  = data_in;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = hold_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_FRAMER_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^hold_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = hold_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_FRAMER_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      hold_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed plus random frames for uart_tx_framer, checked against a
// bit-list model of the serial frame (start, 8 data LSB first, [parity], stop).
module tb_uart_tx_framer;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit exp_bits[$];

  uart_tx_framer #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build(input logic [7:0] b);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_FRAMER_PARITY_EN
    exp_bits.push_back(^b);
`endif
    exp_bits.push_back(1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    data_in = b;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("accept_ready", data_ready, 1);
    step();
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit toggle,
                           input int ncyc);
    int lim;
    build(b);
    lim = exp_bits.size() * BD;
    if (ncyc > 0 && ncyc < lim) lim = ncyc;
    for (int c = 0; c < lim; c++) begin
      if (toggle) data_in = 8'($urandom);
      check("frame_tx", tx, exp_bits[c / BD]);
      check("frame_busy", busy, 1);
      check("frame_ready", data_ready, 0);
      step();
    end
  endtask

  task automatic frame_end();
    check("end_tx", tx, 1);
    check("end_busy", busy, 0);
    check("end_ready", data_ready, 1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      step();
    end
  endtask

  initial begin
    logic [7:0] b;
    int gap;

    rst = 1'b0;
    repeat (3) step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", data_ready, 0);
    rst = 1'b1;
    step();
    check("post_rst_ready", data_ready, 1);
    idle_check(10);

    accept(8'h55, 1'b0);
    run_frame(8'h55, 1'b0, 0);
    frame_end();

    accept(8'hA3, 1'b1);
    data_in = 8'h0F;
    run_frame(8'hA3, 1'b0, 0);
    frame_end();
    step();
    data_valid = 1'b0;
    run_frame(8'h0F, 1'b0, 0);
    frame_end();

    accept(8'hFF, 1'b0);
    run_frame(8'hFF, 1'b0, 4 * BD + 2);
    rst = 1'b0;
    #1;
    check("abort_ready_comb", data_ready, 0);
    step();
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", data_ready, 0);
    step();
    rst = 1'b1;
    step();
    check("release_ready", data_ready, 1);
    idle_check(50);

    accept(8'h81, 1'b0);
    run_frame(8'h81, 1'b1, 0);
    frame_end();

    accept(8'h07, 1'b0);
    run_frame(8'h07, 1'b0, 0);
    frame_end();
    accept(8'h03, 1'b0);
    run_frame(8'h03, 1'b0, 0);
    frame_end();

    repeat (20) begin
      gap = $urandom_range(0, 5);
      idle_check(gap);
      b = 8'($urandom);
      accept(b, 1'b0);
      run_frame(b, 1'($urandom_range(0, 1)), 0);
      frame_end();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
